// File: rtl/prime_scan_pkg.sv
// prime_scan_pkg: shared widths and FSM state encoding for the prime scan sequencer.
package prime_scan_pkg;
  localparam int DET_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/prime_scan_ctrl.sv
// prime_scan_ctrl: sweeps the prime detector input from lo to hi and reports
// the prime count and the largest prime seen.
module prime_scan_ctrl
  import prime_scan_pkg::*;
#(
  parameter int W     = DET_W,
  parameter int CNT_W = W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     lo,
  input  logic [W-1:0]     hi,
  output logic [W-1:0]     det_s,
  input  logic             det_prime,
  output logic             busy,
  output logic             done,
  output logic             range_err,
  output logic [CNT_W-1:0] prime_cnt,
  output logic [W-1:0]     last_prime,
  output logic             found
);
  state_t state, state_nxt;
  logic [W-1:0] hi_q;
  logic at_end;
  assign at_end = det_s == hi_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start ? ((lo <= hi) ? SCAN : FIN) : IDLE;
      SCAN: state_nxt = abort ? IDLE : (at_end ? FIN : SCAN);
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state == SCAN;
    done = state == FIN;
  end
  // Termination is by equality with hi_q, so a sweep ending at 2^W-1 never wraps det_s.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi_q       <= '0;
      det_s      <= '0;
      prime_cnt  <= '0;
      last_prime <= '0;
      found      <= 1'b0;
      range_err  <= 1'b0;
    end else if (state == IDLE && start) begin
      prime_cnt  <= '0;
      last_prime <= '0;
      found      <= 1'b0;
      range_err  <= lo > hi;
      if (lo <= hi) begin
        hi_q  <= hi;
        det_s <= lo;
      end
    end else if (state == SCAN && !abort) begin
      if (det_prime) begin
        prime_cnt  <= prime_cnt + CNT_W'(1);
        last_prime <= det_s;
        found      <= 1'b1;
      end
      if (!at_end) det_s <= det_s + W'(1);
    end
endmodule

// File: tb/tb_prime_scan_ctrl.sv
// tb_prime_scan_ctrl: directed and randomized sweeps checked against a trial-division
// prime model; the bench also plays the role of the combinational detector.
module tb_prime_scan_ctrl;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       start = 0;
  logic       abort = 0;
  logic [3:0] lo = 0;
  logic [3:0] hi = 0;
  logic [3:0] det_s;
  logic       det_prime;
  logic       busy, done, range_err, found;
  logic [4:0] prime_cnt;
  logic [3:0] last_prime;
  int n_cmp = 0;
  int n_bad = 0;

  prime_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .lo(lo), .hi(hi),
    .det_s(det_s), .det_prime(det_prime), .busy(busy), .done(done),
    .range_err(range_err), .prime_cnt(prime_cnt), .last_prime(last_prime), .found(found)
  );

  always #5 clk = ~clk;

  function automatic bit is_prime(int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d * d <= v; d++) if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  assign det_prime = is_prime(int'(det_s));

  task automatic check(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_results(string tag, int a, int b, bit err);
    int cnt = 0;
    int last = 0;
    for (int v = a; v <= b; v++) if (is_prime(v)) begin cnt++; last = v; end
    check({tag, ".prime_cnt"}, int'(prime_cnt), cnt);
    check({tag, ".last_prime"}, int'(last_prime), last);
    check({tag, ".found"}, int'(found), int'(cnt != 0));
    check({tag, ".range_err"}, int'(range_err), int'(err));
  endtask

  task automatic check_idle_zero(string tag);
    check({tag, ".det_s"}, int'(det_s), 0);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".done"}, int'(done), 0);
    check_results(tag, 1, 0, 1'b0);
  endtask

  // abort_at / start_at: SCAN cycle index to assert abort / a stray start, -1 for none.
  task automatic sweep(int lo_v, int hi_v, int abort_at, int start_at);
    int n = hi_v - lo_v + 1;
    @(negedge clk);
    start = 1; lo = 4'(lo_v); hi = 4'(hi_v);
    @(negedge clk);
    start = 0; lo = 4'($urandom); hi = 4'($urandom);
    if (lo_v > hi_v) begin
      check("err.done", int'(done), 1);
      check("err.busy", int'(busy), 0);
      check_results("err", 1, 0, 1'b1);
      @(negedge clk);
      check("err.done_after", int'(done), 0);
      check("err.busy_after", int'(busy), 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      check("scan.busy", int'(busy), 1);
      check("scan.done", int'(done), 0);
      check("scan.det_s", int'(det_s), lo_v + i);
      if (i == start_at) start = 1;
      if (i == abort_at) begin
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort.busy", int'(busy), 0);
        check("abort.done", int'(done), 0);
        check_results("abort", lo_v, lo_v + i - 1, 1'b0);
        @(negedge clk);
        check("abort.done_later", int'(done), 0);
        check("abort.busy_later", int'(busy), 0);
        return;
      end
      @(negedge clk);
      start = 0;
    end
    check("fin.done", int'(done), 1);
    check("fin.busy", int'(busy), 0);
    check("fin.det_s", int'(det_s), hi_v);
    check_results("fin", lo_v, hi_v, 1'b0);
    @(negedge clk);
    check("idle.done", int'(done), 0);
    check("idle.busy", int'(busy), 0);
    check("idle.det_s_hold", int'(det_s), hi_v);
    check_results("idle", lo_v, hi_v, 1'b0);
  endtask

  initial begin
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    check_idle_zero("quiet");
    sweep(0, 15, -1, -1);
    sweep(8, 12, -1, -1);
    sweep(7, 7, -1, -1);
    sweep(9, 9, -1, -1);
    sweep(10, 3, -1, -1);
    sweep(0, 15, 4, -1);
    repeat (2) @(negedge clk);
    check_results("abort_hold", 0, 3, 1'b0);
    sweep(0, 15, -1, 3);
    @(negedge clk);
    start = 1; lo = 4'd0; hi = 4'd15;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    check_idle_zero("async_rst");
    #2 rst_n = 1;
    @(negedge clk);
    check_idle_zero("after_rst");
    sweep(2, 5, -1, -1);
    for (int t = 0; t < 25; t++) begin
      int a = int'($urandom_range(0, 15));
      int b = int'($urandom_range(0, 15));
      int ab = -1;
      if (a <= b && $urandom_range(0, 2) == 0) begin
        ab = int'($urandom_range(0, b - a));
        if (is_prime(a + ab)) ab = -1;
      end
      sweep(a, b, ab, ($urandom_range(0, 3) == 0) ? 0 : -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
